// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: opcode encodings,
// the per-instruction control bundle and the forwarding select codes.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_WB   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic mem_read;
    logic mem_write;
    logic alusrc;
    logic branch;
    logic imm_add;
    logic imm_or;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // The younger producer (MEM) holds the newer value, so it wins over WB.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    return mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_NONE);
  endfunction

endpackage

// File: rtl/pipe_ctrl_dec.sv
// Combinational opcode decoder: turns the ID-stage opcode into the control
// bundle, the destination register and a jump flag. Unknown opcodes give an
// all-zero bundle and destination 0.
module pipe_ctrl_dec
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OP_W   = 6
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  output ctrl_t             ctrl,
  output logic [REG_AW-1:0] dest,
  output logic              jmp
);

  logic [5:0] op;
  assign op = 6'(opcode);

  // Opcode to control bundle lookup.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl = CTRL_NOP;
    dest = '0;
    jmp  = 1'b0;
    case (op)
      OP_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        dest          = rd;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.mem_read = 1'b1;
        dest          = rt;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        dest           = rt;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.imm_add  = 1'b1;
        dest          = rt;
      end
      OP_ORI: begin
        ctrl.regwrite = 1'b1;
        ctrl.imm_or   = 1'b1;
        dest          = rt;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alusrc = 1'b1;
        ctrl.branch = 1'b1;
        dest        = rt;
      end
      OP_J: begin
        ctrl.alusrc = 1'b1;
        jmp         = 1'b1;
        dest        = rt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: carries the decoded control bundle from
// ID through EX, MEM and WB, and resolves stall, flush and forwarding.
// Build option: define PIPE_CTRL_FWD_EN to enable operand forwarding; the
// stall then covers load-use only. Without it, forwarding selects stay 0
// and ID interlocks on any pending writer in EX or MEM.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush,
  output logic              id_jmp,
  output logic              ex_alusrc,
  output logic              ex_imm_add,
  output logic              ex_imm_or,
  output logic              ex_branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
  } ex_stage_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic              mem_read;
    logic              mem_write;
    logic [REG_AW-1:0] dest;
  } mem_stage_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] dest;
  } wb_stage_t;

  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] id_dest;
  logic              id_is_jmp;

  ex_stage_t  ex_d, ex_q;
  mem_stage_t mem_q;
  wb_stage_t  wb_q;

  logic ex_match;
  logic load_use;
  logic hazard;
  logic unused_bits;

  pipe_ctrl_dec #(
    .REG_AW(REG_AW),
    .OP_W  (OP_W)
  ) u_dec (
    .opcode(id_opcode),
    .rt    (id_rt),
    .rd    (id_rd),
    .ctrl  (id_ctrl),
    .dest  (id_dest),
    .jmp   (id_is_jmp)
  );

  // Register 0 is hardwired, so a zero destination never creates a hazard.
  assign ex_match = (ex_q.dest != '0) && ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));
  assign load_use = id_valid && ex_q.valid && ex_q.ctrl.mem_read && ex_match;

`ifdef PIPE_CTRL_FWD_EN
  assign hazard = load_use;

  assign fwd_a = fwd_pick(mem_q.regwrite && (mem_q.dest != '0) && (mem_q.dest == ex_q.rs),
                          wb_q.regwrite  && (wb_q.dest  != '0) && (wb_q.dest  == ex_q.rs));
  assign fwd_b = fwd_pick(mem_q.regwrite && (mem_q.dest != '0) && (mem_q.dest == ex_q.rt),
                          wb_q.regwrite  && (wb_q.dest  != '0) && (wb_q.dest  == ex_q.rt));

  assign unused_bits = mem_q.valid;
`else
  logic mem_match;
  assign mem_match = (mem_q.dest != '0) && ((mem_q.dest == id_rs) || (mem_q.dest == id_rt));
  assign hazard    = id_valid && ((ex_q.valid && ex_q.ctrl.regwrite && ex_match) ||
                                  (mem_q.valid && mem_q.regwrite && mem_match));

  assign fwd_a = FWD_NONE;
  assign fwd_b = FWD_NONE;

  assign unused_bits = ^{ex_q.rs, ex_q.rt};
`endif

  // A taken branch squashes ID, which overrides any stall in the same cycle.
  assign stall  = hazard && !ex_br_taken && !rst;
  assign id_jmp = id_valid && id_is_jmp && !rst;
  assign flush  = (id_jmp || ex_br_taken) && !rst;

  // Next EX contents: the ID instruction, or a bubble on idle/stall/flush.
  always_comb begin
    ex_d = '0;
    if (id_valid && !hazard && !ex_br_taken) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = id_ctrl;
      ex_d.rs    = id_rs;
      ex_d.rt    = id_rt;
      ex_d.dest  = id_dest;
    end
  end

  // Pipeline registers: EX/MEM/WB always advance; reset fills them with bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of its predecessor.
      ex_q            <= ex_d;
      mem_q.valid     <= ex_q.valid;
      mem_q.regwrite  <= ex_q.ctrl.regwrite;
      mem_q.memtoreg  <= ex_q.ctrl.memtoreg;
      mem_q.mem_read  <= ex_q.ctrl.mem_read;
      mem_q.mem_write <= ex_q.ctrl.mem_write;
      mem_q.dest      <= ex_q.dest;
      wb_q.regwrite   <= mem_q.regwrite;
      wb_q.memtoreg   <= mem_q.memtoreg;
      wb_q.dest       <= mem_q.dest;
    end
  end

  assign ex_alusrc   = ex_q.ctrl.alusrc;
  assign ex_imm_add  = ex_q.ctrl.imm_add;
  assign ex_imm_or   = ex_q.ctrl.imm_or;
  assign ex_branch   = ex_q.ctrl.branch;
  assign mem_read    = mem_q.mem_read;
  assign mem_write   = mem_q.mem_write;
  assign wb_regwrite = wb_q.regwrite;
  assign wb_memtoreg = wb_q.memtoreg;
  assign wb_dest     = wb_q.dest;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl. Each stimulus row drives the ID-stage
// inputs for one cycle and queues the hand-computed outputs for that cycle;
// a monitor pops and compares them on the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       ex_br_taken = 1'b0;

  logic       stall, flush, id_jmp;
  logic       ex_alusrc, ex_imm_add, ex_imm_or, ex_branch;
  logic       mem_read, mem_write, wb_regwrite, wb_memtoreg;
  logic [4:0] wb_dest;
  logic [1:0] fwd_a, fwd_b;

  typedef struct packed {
    logic       s, f, j;
    logic [3:0] ex;   // alusrc, imm_add, imm_or, branch
    logic [1:0] mem;  // mem_read, mem_write
    logic [1:0] wb;   // regwrite, memtoreg
    logic [4:0] d;
    logic [1:0] fa, fb;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string tag;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  pipe_ctrl #(.REG_AW(5), .OP_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .ex_br_taken(ex_br_taken),
    .stall      (stall),
    .flush      (flush),
    .id_jmp     (id_jmp),
    .ex_alusrc  (ex_alusrc),
    .ex_imm_add (ex_imm_add),
    .ex_imm_or  (ex_imm_or),
    .ex_branch  (ex_branch),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg),
    .wb_dest    (wb_dest),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  always #5 clk = ~clk;

  function automatic obs_t o(input logic s, input logic f, input logic j,
                             input logic [3:0] ex, input logic [1:0] mem,
                             input logic [1:0] wb, input logic [4:0] d,
                             input logic [1:0] fa, input logic [1:0] fb);
    obs_t r;
    r = '{s: s, f: f, j: j, ex: ex, mem: mem, wb: wb, d: d, fa: fa, fb: fb};
    return r;
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("stall=%b flush=%b jmp=%b ex=%b mem=%b wb=%b dest=%0d fa=%b fb=%b",
                     v.s, v.f, v.j, v.ex, v.mem, v.wb, v.d, v.fa, v.fb);
  endfunction

  task automatic check(input string tag, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got [%s] want [%s]", tag, fmt(act), fmt(exp));
    end
  endtask

  // Drive one cycle of ID inputs and queue the outputs expected in that cycle.
  task automatic cyc(input string tag, input logic r, input logic v, input logic [5:0] op,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic br, input obs_t e);
    item_t it;
    @(posedge clk);
    #1;
    rst         = r;
    id_valid    = v;
    id_opcode   = op;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    ex_br_taken = br;
    it.exp = e;
    it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic idle(input string tag, input obs_t e);
    cyc(tag, 1'b0, 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, e);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest queued row.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      obs_t  act;
      it  = sb.pop_front();
      act = '{s: stall, f: flush, j: id_jmp,
              ex: {ex_alusrc, ex_imm_add, ex_imm_or, ex_branch},
              mem: {mem_read, mem_write}, wb: {wb_regwrite, wb_memtoreg},
              d: wb_dest, fa: fwd_a, fb: fwd_b};
      check(it.tag, act, it.exp);
    end
  end

  obs_t z;

  initial begin
    z = '0;

    // Reset gates combinational outputs even with j and a taken branch present.
    cyc("rst_hold", 1, 1, OP_J, 5'd0, 5'd0, 5'd0, 1, z);
    idle("rst_release", z);

    // lw $8 then add using rs=8.
    cyc("lu_lw", 0, 1, OP_LW, 5'd1, 5'd8, 5'd0, 0, z);
    cyc("lu_stall1", 0, 1, OP_R, 5'd8, 5'd2, 5'd9, 0, o(1,0,0,4'b0000,2'b00,2'b00,5'd0,2'b00,2'b00));
`ifdef PIPE_CTRL_FWD_EN
    cyc("lu_go", 0, 1, OP_R, 5'd8, 5'd2, 5'd9, 0, o(0,0,0,4'b0000,2'b10,2'b00,5'd0,2'b00,2'b00));
    idle("lu_add_ex_fwd", o(0,0,0,4'b1000,2'b00,2'b11,5'd8,2'b01,2'b00));
    idle("lu_add_mem", z);
    idle("lu_add_wb", o(0,0,0,4'b0000,2'b00,2'b10,5'd9,2'b00,2'b00));
    idle("lu_drain", z);
`else
    cyc("lu_stall2", 0, 1, OP_R, 5'd8, 5'd2, 5'd9, 0, o(1,0,0,4'b0000,2'b10,2'b00,5'd0,2'b00,2'b00));
    cyc("lu_go", 0, 1, OP_R, 5'd8, 5'd2, 5'd9, 0, o(0,0,0,4'b0000,2'b00,2'b11,5'd8,2'b00,2'b00));
    idle("lu_add_ex", o(0,0,0,4'b1000,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("lu_add_mem", z);
    idle("lu_add_wb", o(0,0,0,4'b0000,2'b00,2'b10,5'd9,2'b00,2'b00));
`endif

    // add $3 then add rs=3 back-to-back.
    cyc("rr_add1", 0, 1, OP_R, 5'd1, 5'd2, 5'd3, 0, z);
`ifdef PIPE_CTRL_FWD_EN
    cyc("rr_add2", 0, 1, OP_R, 5'd3, 5'd4, 5'd5, 0, o(0,0,0,4'b1000,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("rr_fwd_mem", o(0,0,0,4'b1000,2'b00,2'b00,5'd0,2'b10,2'b00));
    idle("rr_add1_wb", o(0,0,0,4'b0000,2'b00,2'b10,5'd3,2'b00,2'b00));
    idle("rr_add2_wb", o(0,0,0,4'b0000,2'b00,2'b10,5'd5,2'b00,2'b00));
    idle("rr_drain", z);
`else
    cyc("rr_stall1", 0, 1, OP_R, 5'd3, 5'd4, 5'd5, 0, o(1,0,0,4'b1000,2'b00,2'b00,5'd0,2'b00,2'b00));
    cyc("rr_stall2", 0, 1, OP_R, 5'd3, 5'd4, 5'd5, 0, o(1,0,0,4'b0000,2'b00,2'b00,5'd0,2'b00,2'b00));
    cyc("rr_go", 0, 1, OP_R, 5'd3, 5'd4, 5'd5, 0, o(0,0,0,4'b0000,2'b00,2'b10,5'd3,2'b00,2'b00));
    idle("rr_add2_ex", o(0,0,0,4'b1000,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("rr_add2_mem", z);
    idle("rr_add2_wb", o(0,0,0,4'b0000,2'b00,2'b10,5'd5,2'b00,2'b00));
`endif

    // Taken branch while load-use is pending: flush wins, EX gets a bubble.
    cyc("br_lw", 0, 1, OP_LW, 5'd0, 5'd7, 5'd0, 0, z);
    cyc("br_flush", 0, 1, OP_R, 5'd7, 5'd0, 5'd10, 1, o(0,1,0,4'b0000,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("br_ex_bubble", o(0,0,0,4'b0000,2'b10,2'b00,5'd0,2'b00,2'b00));
    idle("br_lw_wb", o(0,0,0,4'b0000,2'b00,2'b11,5'd7,2'b00,2'b00));
    idle("br_squashed", z);

    // Jump in ID.
    cyc("jmp_id", 0, 1, OP_J, 5'd0, 5'd0, 5'd0, 0, o(0,1,1,4'b0000,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("jmp_ex", o(0,0,0,4'b1000,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("jmp_mem", z);

    // Unknown opcode flows through as all-zero controls.
    cyc("bad_id", 0, 1, OP_BAD, 5'd1, 5'd2, 5'd3, 0, z);
    idle("bad_ex", z);
    idle("bad_mem", z);
    idle("bad_wb", z);

    // Write to $0 then reader of $0: no stall, no forward.
    cyc("r0_addi", 0, 1, OP_ADDI, 5'd1, 5'd0, 5'd0, 0, z);
    cyc("r0_reader", 0, 1, OP_R, 5'd0, 5'd0, 5'd4, 0, o(0,0,0,4'b0100,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("r0_reader_ex", o(0,0,0,4'b1000,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("r0_addi_wb", o(0,0,0,4'b0000,2'b00,2'b10,5'd0,2'b00,2'b00));
    idle("r0_reader_wb", o(0,0,0,4'b0000,2'b00,2'b10,5'd4,2'b00,2'b00));

    // Reset pulsed mid-stall, then sw/ori/beq decode normally.
    cyc("rs_lw", 0, 1, OP_LW, 5'd0, 5'd6, 5'd0, 0, z);
    cyc("rs_stall", 0, 1, OP_R, 5'd6, 5'd0, 5'd1, 0, o(1,0,0,4'b0000,2'b00,2'b00,5'd0,2'b00,2'b00));
    cyc("rs_async", 1, 1, OP_R, 5'd6, 5'd0, 5'd1, 0, z);
    cyc("rs_sw_id", 0, 1, OP_SW, 5'd0, 5'd5, 5'd0, 0, z);
    cyc("rs_ori_id", 0, 1, OP_ORI, 5'd0, 5'd11, 5'd0, 0, z);
    cyc("rs_sw_mem", 0, 1, OP_BEQ, 5'd1, 5'd2, 5'd0, 0, o(0,0,0,4'b0010,2'b01,2'b00,5'd0,2'b00,2'b00));
    idle("rs_beq_ex", o(0,0,0,4'b1001,2'b00,2'b00,5'd5,2'b00,2'b00));
    idle("rs_ori_wb", o(0,0,0,4'b0000,2'b00,2'b10,5'd11,2'b00,2'b00));
    idle("rs_beq_wb", o(0,0,0,4'b0000,2'b00,2'b00,5'd2,2'b00,2'b00));

    // add $12 then sw reading rt=12.
    cyc("rt_add", 0, 1, OP_R, 5'd0, 5'd0, 5'd12, 0, z);
`ifdef PIPE_CTRL_FWD_EN
    cyc("rt_sw", 0, 1, OP_SW, 5'd0, 5'd12, 5'd0, 0, o(0,0,0,4'b1000,2'b00,2'b00,5'd0,2'b00,2'b00));
    idle("rt_fwd_b", o(0,0,0,4'b0000,2'b00,2'b00,5'd0,2'b00,2'b10));
    idle("rt_sw_mem", o(0,0,0,4'b0000,2'b01,2'b10,5'd12,2'b00,2'b00));
    idle("rt_sw_wb", o(0,0,0,4'b0000,2'b00,2'b00,5'd12,2'b00,2'b00));
`else
    cyc("rt_stall1", 0, 1, OP_SW, 5'd0, 5'd12, 5'd0, 0, o(1,0,0,4'b1000,2'b00,2'b00,5'd0,2'b00,2'b00));
    cyc("rt_stall2", 0, 1, OP_SW, 5'd0, 5'd12, 5'd0, 0, o(1,0,0,4'b0000,2'b00,2'b00,5'd0,2'b00,2'b00));
    cyc("rt_go", 0, 1, OP_SW, 5'd0, 5'd12, 5'd0, 0, o(0,0,0,4'b0000,2'b00,2'b10,5'd12,2'b00,2'b00));
    idle("rt_sw_ex", z);
    idle("rt_sw_mem", o(0,0,0,4'b0000,2'b01,2'b00,5'd0,2'b00,2'b00));
    idle("rt_sw_wb", o(0,0,0,4'b0000,2'b00,2'b00,5'd12,2'b00,2'b00));
`endif
    idle("end_drain", z);

    // Let the monitor consume the remaining rows, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d rows left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter OP_W, default 6, opcode width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_opcode  input  OP_W  ID-stage opcode.
REQ-007 id_rs, id_rt, id_rd  input  REG_AW each  ID-stage register fields.
REQ-008 ex_br_taken  input  1  EX-stage branch resolved taken.
REQ-009 stall  output  1  hold PC and IF/ID (combinational).
REQ-010 flush  output  1  squash IF/ID (combinational).
REQ-011 id_jmp  output  1  ID holds a jump (combinational).
REQ-012 ex_alusrc, ex_imm_add, ex_imm_or, ex_branch  output  1 each  EX-stage controls.
REQ-013 mem_read, mem_write  output  1 each  MEM-stage controls.
REQ-014 wb_regwrite, wb_memtoreg  output  1 each  WB-stage controls.
REQ-015 wb_dest  output  REG_AW  WB destination register.
REQ-016 fwd_a, fwd_b  output  2 each  EX operand forwarding selects.

Function
REQ-017 Decode SHALL be: R 000000, lw 100011, sw 101011, addi 001000, ori 001101, beq 000100, bne 000101, j 000010; any other opcode decodes to all-zero controls.
REQ-018 Bundle SHALL be: regwrite=R|lw|addi|ori; memtoreg=mem_read=lw; mem_write=sw; alusrc=~(lw|sw|addi|ori); branch=beq|bne; imm_add=addi; imm_or=ori; dest=R?rd:rt.
REQ-019 Bundle plus rs/rt/dest SHALL register ID->EX->MEM->WB, one stage per cycle; WB outputs lag ID by 3 cycles.
REQ-020 Bubble SHALL mean all-zero bundle, valid=0, dest=0.
REQ-021 id_valid=0 SHALL load a bubble into EX.
REQ-022 Load-use: EX valid & mem_read & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt) & id_valid -> stall=1, bubble into EX, EX/MEM/WB advance.
REQ-023 id_jmp=id_valid&j; flush=id_jmp|ex_br_taken.
REQ-024 ex_br_taken=1 SHALL load bubble into EX and force stall=0 (flush beats stall same cycle).
REQ-025 Destination 0 SHALL never produce a hazard, stall or forward.

Reset
REQ-026 rst=1 SHALL asynchronously clear all pipeline registers to bubble; every output reads 0 during and immediately after reset.
REQ-027 rst asserted mid-stall or mid-flush SHALL discard in-flight instructions; first post-reset cycle with id_valid=1 decodes normally.

Configuration
REQ-028 Macro PIPE_CTRL_FWD_EN defined: fwd_a=2'b10 if MEM regwrite & mem_dest!=0 & mem_dest==ex_rs, else 2'b01 if WB regwrite & wb_dest!=0 & wb_dest==ex_rs, else 2'b00 (MEM priority); fwd_b likewise on ex_rt; stall per REQ-022 only.
REQ-029 Macro undefined: fwd_a=fwd_b=0; stall asserts on any ID rs/rt match with a valid regwrite destination!=0 in EX or MEM (interlock, up to 2 cycles).

Structure
REQ-030 Package pipe_ctrl_pkg SHALL hold opcode constants, ctrl-bundle struct typedef, fwd-select constants (FWD_NONE=0, FWD_WB=1, FWD_MEM=2).
REQ-031 Decode SHALL be sub-module pipe_ctrl_dec (combinational opcode->bundle); pipeline, hazard and forward logic in pipe_ctrl.

Verification
REQ-032 lw $8 then add using rs=8 -> stall=1 one cycle, EX bubble, add reaches WB 4 cycles after lw's WB-1; FWD_EN: fwd_a=01 in add's EX.
REQ-033 add $3; add rs=3 back-to-back -> FWD_EN: fwd_a=10, no stall; non-FWD: stall 2 cycles.
REQ-034 beq in EX with ex_br_taken=1 while load-use true -> flush=1, stall=0, EX bubble.
REQ-035 Opcode 111111 id_valid=1 -> all controls 0 through WB, wb_regwrite=0.
REQ-036 Write to $0 (addi rt=0) followed by reader of $0 -> no stall, fwd=00.
REQ-037 rst pulsed during stall -> all outputs 0 asynchronously; next sw decodes mem_write=1 two cycles later.
